// File: rtl/mux_pkg.sv
// Shared constants and helpers for the mux_1 selector family.
// sat_inc is kept 32 bits wide so that counters of any width up to MAX_CNT_W can reuse it.
package mux_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 8;
  localparam int MAX_CNT_W = 32;

  // Returns value + 1, or holds at max_value once it has been reached.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(
    input logic [MAX_CNT_W-1:0] value,
    input logic [MAX_CNT_W-1:0] max_value
  );
    logic [MAX_CNT_W-1:0] result;
    if (value >= max_value) begin
      result = max_value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_1_if.sv
// Bundle of the mux_1 data, select and status signals.
// The master side drives the data and select inputs; the slave side is the mux itself.
interface mux_1_if
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             s0;
  logic             in_valid;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             out_valid;
  logic [CNT_W-1:0] sel_toggles;

  modport master (
    output a, b, s0, in_valid,
    input  y, y_q, out_valid, sel_toggles
  );

  modport slave (
    input  a, b, s0, in_valid,
    output y, y_q, out_valid, sel_toggles
  );

endinterface

// File: rtl/mux_1_sat_cnt.sv
// Saturating up-counter: it increments on inc and sticks at all-ones.
// CNT_W must be in the range 1..MAX_CNT_W.
module mux_1_sat_cnt
  import mux_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [MAX_CNT_W-1:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;

  // Next count value, saturated at CNT_MAX.
  always_comb begin
    count_nxt_s = count_r;
    if (inc) begin
      count_nxt_s = CNT_W'(sat_inc(32'(count_r), CNT_MAX));
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/mux_1.sv
// Parameterised 2:1 selector. It has a combinational output y, a registered copy y_q
// with a valid flag, and a saturating count of s0 changes.
module mux_1
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic    clk,
  input  logic    rst,
  mux_1_if.slave  bus
);

  logic [WIDTH-1:0] y_s;
  logic [WIDTH-1:0] y_q_r;
  logic             out_valid_r;
  logic             s0_d_r;
  logic             toggle_s;
  logic [CNT_W-1:0] toggles_s;

  // Zero-latency selection. Reset deliberately has no effect on this path.
  always_comb begin
    y_s = bus.a;
    if (bus.s0) begin
      y_s = bus.b;
    end else begin
      y_s = bus.a;
    end
  end

  // s0 differs from its value at the previous edge.
  always_comb begin
    toggle_s = (bus.s0 != s0_d_r);
  end

  // Registered sample path and delayed copy of the select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q_r       <= '0;
      out_valid_r <= 1'b0;
      s0_d_r      <= 1'b0;
    end else begin
      s0_d_r <= bus.s0;
      if (bus.in_valid) begin
        y_q_r       <= y_s;
        out_valid_r <= 1'b1;
      end else begin
        y_q_r       <= y_q_r;
        out_valid_r <= 1'b0;
      end
    end
  end

  mux_1_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_sat_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (toggle_s),
    .count (toggles_s)
  );

  assign bus.y           = y_s;
  assign bus.y_q         = y_q_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.sel_toggles = toggles_s;

endmodule

// File: tb/tb_mux_1.sv
// Self-checking bench for mux_1. It drives a WIDTH=1/CNT_W=8 instance and a WIDTH=8/CNT_W=2 instance
// in lockstep, using a truth table, directed corner sequences and random traffic checked against a model.
module tb_mux_1;

  logic clk;
  logic rst;

  mux_1_if #(.WIDTH(1), .CNT_W(8)) if1 ();
  mux_1_if #(.WIDTH(8), .CNT_W(2)) if8 ();

  mux_1 #(.WIDTH(1), .CNT_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  mux_1 #(.WIDTH(8), .CNT_W(2)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state kept as plain values, not as an image of the RTL.
  logic       m1_yq;
  logic       m1_ov;
  int         m1_tog;
  logic [7:0] m8_yq;
  logic       m8_ov;
  int         m8_tog;
  logic       m_prev_s0;

  typedef struct {
    logic       a;
    logic       b;
    logic       s0;
    logic       y;
    logic [7:0] y8;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic a1, input logic b1, input logic [7:0] a8, input logic [7:0] b8,
                       input logic s0, input logic iv);
    if1.a = a1;  if1.b = b1;  if1.s0 = s0;  if1.in_valid = iv;
    if8.a = a8;  if8.b = b8;  if8.s0 = s0;  if8.in_valid = iv;
  endtask

  task automatic model_reset();
    m1_yq = 1'b0;  m1_ov = 1'b0;  m1_tog = 0;
    m8_yq = 8'h00; m8_ov = 1'b0;  m8_tog = 0;
    m_prev_s0 = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_y1"},   32'(if1.y),           32'(if1.s0 ? if1.b : if1.a));
    check({tag, "_y8"},   32'(if8.y),           32'(if8.s0 ? if8.b : if8.a));
    check({tag, "_yq1"},  32'(if1.y_q),         32'(m1_yq));
    check({tag, "_ov1"},  32'(if1.out_valid),   32'(m1_ov));
    check({tag, "_tog1"}, 32'(if1.sel_toggles), 32'(m1_tog));
    check({tag, "_yq8"},  32'(if8.y_q),         32'(m8_yq));
    check({tag, "_ov8"},  32'(if8.out_valid),   32'(m8_ov));
    check({tag, "_tog8"}, 32'(if8.sel_toggles), 32'(m8_tog));
  endtask

  // One rising edge: advance the model from the inputs held across the edge, then compare.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (if1.s0 != m_prev_s0) begin
        m1_tog = (m1_tog < 255) ? m1_tog + 1 : 255;
        m8_tog = (m8_tog < 3) ? m8_tog + 1 : 3;
      end
      m_prev_s0 = if1.s0;
      if (if1.in_valid) begin
        m1_yq = if1.s0 ? if1.b : if1.a;
        m8_yq = if8.s0 ? if8.b : if8.a;
        m1_ov = 1'b1;
        m8_ov = 1'b1;
      end else begin
        m1_ov = 1'b0;
        m8_ov = 1'b0;
      end
    end
    #1;
    check_all(tag);
  endtask

  // Assert reset away from any edge and confirm the registered outputs clear at once.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h3C};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h3C};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h3C};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA5};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h3C};

    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    model_reset();
    #1;
    check_all("reset");

    // Truth-table sweep under reset: y must still follow its inputs.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].a, tbl[i].b, 8'hA5, 8'h3C, tbl[i].s0, 1'b0);
      #10;
      check($sformatf("tt_y1_%0d", i), 32'(if1.y), 32'(tbl[i].y));
      check($sformatf("tt_y8_%0d", i), 32'(if8.y), 32'(tbl[i].y8));
      check($sformatf("tt_ov_%0d", i), 32'(if1.out_valid), 32'd0);
    end

    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Latency: one sample in, then hold with in_valid low.
    drive(1'b1, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b1);
    cycle("lat_in");
    check("lat_yq_is1", 32'(if1.y_q), 32'd1);
    check("lat_ov_is1", 32'(if1.out_valid), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    cycle("lat_hold");
    check("hold_yq_is1", 32'(if1.y_q), 32'd1);
    check("hold_ov_is0", 32'(if1.out_valid), 32'd0);

    // Async reset with y_q=1 and out_valid=1.
    drive(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1);
    cycle("pre_rst");
    async_reset("async_rst");
    check("rst_yq_is0", 32'(if1.y_q), 32'd0);
    check("rst_ov_is0", 32'(if1.out_valid), 32'd0);
    drive(1'b0, 1'b1, 8'h12, 8'h34, 1'b1, 1'b0);
    #1;
    check("rst_y_follows", 32'(if1.y), 32'd1);
    drive(1'b0, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    cycle("post_rst_idle");
    check("post_rst_ov_is0", 32'(if1.out_valid), 32'd0);

    // Toggle counting: 5 changes, then a sixth; the CNT_W=2 copy saturates at 3.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 8'h55, 8'hAA, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
      cycle($sformatf("tog_%0d", i));
    end
    check("tog5_cnt8", 32'(if1.sel_toggles), 32'd5);
    drive(1'b0, 1'b1, 8'h55, 8'hAA, 1'b0, 1'b0);
    cycle("tog_5");
    check("tog6_cnt8", 32'(if1.sel_toggles), 32'd6);
    check("tog6_cnt2_sat", 32'(if8.sel_toggles), 32'd3);
    cycle("tog_steady");
    check("tog_steady_sat", 32'(if8.sel_toggles), 32'd3);

    // Random traffic with occasional asynchronous resets.
    async_reset("rand_start");
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 3) == 0) ? ~if1.s0 : if1.s0, 1'($urandom));
      cycle("rand");
      if ($urandom_range(0, 40) == 0) begin
        async_reset("rand_rst");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
